bcd_serial_adder_seq: RTL and testbench

Sequencer that adds two multi-digit packed-BCD operands one digit per clock. It drives the single-digit BCD adder stage through an external digit port and captures its sum and carry outputs. The block sits directly upstream of the digit adder, feeding it operand digits and carry, and directly downstream of it, collecting each result digit and the ripple carry. It presents a start/busy/done interface to the control logic above it.

---
 rtl/bcd_serial_adder_seq.sv | 137 +++++++++++++
 tb/tb_bcd_serial_adder_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_adder_seq
// Brief    : Digit-serial packed-BCD addition sequencer driving an external
//            combinational single-digit BCD adder. Optional input digit check
//            enabled by defining BCD_SEQ_INPUT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_adder_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [3:0]            add_a,
    output logic [3:0]            add_b,
    output logic                  add_cin,
    input  logic [3:0]            add_sum,
    input  logic                  add_cout,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] C_LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADD    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    logic [4*DIGITS-1:0]  r_a;
    logic [4*DIGITS-1:0]  r_b;
    logic [4*DIGITS-1:0]  r_sum;
    logic [IW-1:0]        r_idx;
    logic                 r_carry;
    logic                 r_cout;
    logic                 r_busy;
    logic                 r_done;
    logic [IW+1:0]        w_sel;
    logic                 w_accept;

    assign w_sel    = {r_idx, 2'b00};
    assign w_accept = (r_state == S_IDLE) && start;

    // r_busy mirrors the ADD state, so it doubles as the digit-port enable
    assign add_a   = r_busy ? r_a[w_sel +: 4] : 4'd0;
    assign add_b   = r_busy ? r_b[w_sel +: 4] : 4'd0;
    assign add_cin = r_busy ? r_carry : 1'b0;

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sum[w_sel +: 4] <= add_sum;
                    r_carry           <= add_cout;
                    if (r_idx == C_LAST_IDX) begin
                        // Final carry captured here so cout is valid alongside done
                        r_cout  <= add_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BCD_SEQ_INPUT_CHECK_EN
    logic [2*DIGITS-1:0] w_dig_bad;
    logic                r_err;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
        assign w_dig_bad[2*gi]     = (a[4*gi +: 4] > 4'd9);
        assign w_dig_bad[2*gi + 1] = (b[4*gi +: 4] > 4'd9);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= |w_dig_bad;
        end
    end

    assign err = r_err;
`else
    logic w_unused;
    assign w_unused = w_accept;
    assign err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder_seq.sv
`default_nettype none
// Scoreboard bench for bcd_serial_adder_seq: a behavioural digit adder feeds
// the DUT, a decimal reference model predicts results, a monitor checks them.
module tb_bcd_serial_adder_seq;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
`ifdef BCD_SEQ_INPUT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clock = ~clock;

    bcd_serial_adder_seq #(.DIGITS(DIGITS)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .a(a), .b(b), .cin(cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    // Behavioural single-digit decimal adder
    always_comb begin
        logic [4:0] s;
        s = 5'(add_a) + 5'(add_b) + 5'(add_cin);
        if (s > 5'd9) begin
            add_cout = 1'b1;
            add_sum  = 4'(s - 5'd10);
        end else begin
            add_cout = 1'b0;
            add_sum  = s[3:0];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t   e;
        longint lim = 1;
        longint t;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        t      = bcd2int(x) + bcd2int(y) + longint'(c);
        e.sum  = int2bcd(t % lim);
        e.cout = (t >= lim);
        e.err  = 1'b0;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Monitor: compares every done pulse against the head of the scoreboard
    always @(negedge clock) begin
        if (reset_n && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
                check("err", 64'(err), 64'(e.err));
            end
        end
        if (reset_n && !busy)
            check("idle_ports", 64'({add_a, add_b, add_cin}), 64'd0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int start_cyc, output int cyc, output int bcnt);
        cyc  = start_cyc;
        bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            tick();
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input exp_t e);
        int cyc, bcnt;
        a = x; b = y; cin = c; start = 1'b1;
        q.push_back(e);
        tick();
        start = 1'b0;
        a = ~x; b = ~y; cin = ~c;
        wait_done(1, cyc, bcnt);
        check("latency", 64'(cyc), 64'(DIGITS + 1));
        check("busy_cycles", 64'(bcnt), 64'(DIGITS));
        tick();
    endtask

    initial begin
        exp_t e;
        int   cyc, bcnt;
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset_n = 1'b1;
        tick();

        e = '{sum: 16'h6912, cout: 1'b0, err: 1'b0};
        run_op(16'h1234, 16'h5678, 1'b0, e);
        e = '{sum: 16'h0000, cout: 1'b1, err: 1'b0};
        run_op(16'h9999, 16'h0001, 1'b0, e);
        e = '{sum: 16'h9999, cout: 1'b1, err: 1'b0};
        run_op(16'h9999, 16'h9999, 1'b1, e);
        check("hold_sum", 64'(sum), 64'h9999);
        check("hold_cout", 64'(cout), 64'd1);

        // Invalid digit: 0xA+0 -> digit 0 with carry, next digit 1
        e = '{sum: 16'h0100, cout: 1'b0, err: CHK_EN};
        run_op(16'h00A0, 16'h0000, 1'b0, e);
        e = '{sum: 16'h0002, cout: 1'b0, err: 1'b0};
        run_op(16'h0001, 16'h0001, 1'b0, e);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] x, y;
            logic         c;
            x = rand_bcd(); y = rand_bcd(); c = 1'($urandom_range(0, 1));
            run_op(x, y, c, model(x, y, c));
        end

        // Start held high and operand changed mid-operation
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        q.push_back(model(16'h1234, 16'h1111, 1'b0));
        tick();
        tick(); tick();
        a = 16'h1111;
        wait_done(3, cyc, bcnt);
        q.push_back(model(16'h1111, 16'h1111, 1'b0));
        tick();
        check("held_start_idle_busy", 64'(busy), 64'd0);
        check("held_start_idle_done", 64'(done), 64'd0);
        tick();
        check("held_start_accept", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(1, cyc, bcnt);
        check("held_start_latency", 64'(cyc), 64'(DIGITS + 1));
        tick();

        // Reset while digit index is 2
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        q.push_back(model(16'h1234, 16'h5678, 1'b0));
        tick();
        start = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        tick();
        q.delete();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_cout", 64'(cout), 64'd0);
        reset_n = 1'b1;
        tick();
        e = '{sum: 16'h0010, cout: 1'b0, err: 1'b0};
        run_op(16'h0005, 16'h0005, 1'b0, e);

        for (int i = 0; i < 5 && q.size() != 0; i++) tick();
        check("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
